// File: rtl/mvm_pkg.sv
// Shared constants and FSM encodings for the matrix-vector multiply datapath.
package mvm_pkg;

  localparam int unsigned Q     = 8380417;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned N     = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned K_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } top_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RUN  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/row_bank_ram.sv
// Simple dual-port N x WIDTH coefficient bank: one write port, one synchronous read port.
module row_bank_ram
  import mvm_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [N];

  // rd_data holds its value while rd_en is low; the drain path uses that as its skid entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/t_row_collector.sv
// Collects out-of-order MVM results into ping-pong row banks and drains each row in index order.
// Optional duplicate-index detection is enabled by defining T_COLLECT_DUP_CHECK_EN.
module t_row_collector
  import mvm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_k_param,
  input  logic             i_res_valid,
  input  logic [WIDTH-1:0] i_res_data,
  input  logic [AW-1:0]    i_res_m_idx,
  output logic             o_row_valid,
  output logic [WIDTH-1:0] o_row_data,
  output logic [AW-1:0]    o_row_idx,
  output logic [3:0]       o_row_i,
  output logic             o_row_last,
  input  logic             i_row_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_dup_err
);

  top_state_t       state_q, state_d;
  drain_state_t     dstate_q, dstate_d;
  logic [3:0]       k_q;
  logic             ovf_q;

  logic             fill_ptr_q;
  logic [AW-1:0]    fill_cnt_q;
  logic [3:0]       fill_row_q;
  logic [1:0]       bank_full_q;
  logic [3:0]       bank_row_q [2];

  logic             drn_ptr_q;
  logic [AW:0]      rd_cnt_q;
  logic             ram_vld_q;
  logic [AW-1:0]    ram_idx_q;

  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;
  logic [AW-1:0]    out_idx_q;
  logic [3:0]       out_row_q;
  logic             out_last_q;

  logic             in_run, smp_cand, smp_acc, smp_drop, fill_done, dup_hit;
  logic             out_adv, rel;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data0, rd_data1, rd_mux;

  // ---------------------------------------------------------------- fill side
  always_comb begin
    in_run    = (state_q == RUN) && !i_start;
    smp_drop  = in_run && i_res_valid && (bank_full_q[fill_ptr_q] || (fill_row_q == k_q));
    smp_cand  = in_run && i_res_valid && !bank_full_q[fill_ptr_q] && (fill_row_q != k_q);
    smp_acc   = smp_cand && !dup_hit;
    fill_done = smp_acc && (fill_cnt_q == AW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr_q <= 1'b0;
      fill_cnt_q <= '0;
      fill_row_q <= '0;
    end else if (i_start) begin
      fill_ptr_q <= 1'b0;
      fill_cnt_q <= '0;
      fill_row_q <= '0;
    end else if (smp_acc) begin
      if (fill_done) begin
        fill_ptr_q <= ~fill_ptr_q;
        fill_cnt_q <= '0;
        fill_row_q <= fill_row_q + 4'd1;
      end else begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end

  // A bank never completes fill and releases drain on the same edge, so set/clear cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q   <= '0;
      bank_row_q[0] <= '0;
      bank_row_q[1] <= '0;
    end else if (i_start) begin
      bank_full_q <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (fill_done && (fill_ptr_q == 1'(b))) begin
          bank_full_q[b] <= 1'b1;
          bank_row_q[b]  <= fill_row_q;
        end else if (rel && (drn_ptr_q == 1'(b))) begin
          bank_full_q[b] <= 1'b0;
        end
      end
    end
  end

`ifdef T_COLLECT_DUP_CHECK_EN
  logic [N-1:0] wmask_q [2];
  logic         dup_q;

  assign dup_hit   = wmask_q[fill_ptr_q][i_res_m_idx];
  assign o_dup_err = dup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmask_q[0] <= '0;
      wmask_q[1] <= '0;
      dup_q      <= 1'b0;
    end else if (i_start) begin
      wmask_q[0] <= '0;
      wmask_q[1] <= '0;
      dup_q      <= 1'b0;
    end else begin
      if (rel) wmask_q[drn_ptr_q] <= '0;
      if (smp_acc) wmask_q[fill_ptr_q][i_res_m_idx] <= 1'b1;
      if (smp_cand && dup_hit) dup_q <= 1'b1;
    end
  end
`else
  assign dup_hit   = 1'b0;
  assign o_dup_err = 1'b0;
`endif

  row_bank_ram u_bank0 (
    .clk     (clk),
    .wr_en   (smp_acc && !fill_ptr_q),
    .wr_addr (i_res_m_idx),
    .wr_data (i_res_data),
    .rd_en   (rd_en && !drn_ptr_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  row_bank_ram u_bank1 (
    .clk     (clk),
    .wr_en   (smp_acc && fill_ptr_q),
    .wr_addr (i_res_m_idx),
    .wr_data (i_res_data),
    .rd_en   (rd_en && drn_ptr_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign rd_mux = drn_ptr_q ? rd_data1 : rd_data0;

  // ---------------------------------------------------------------- drain side
  // The first read is issued from D_IDLE itself so the first beat lands two edges after fill completion.
  always_comb begin
    out_adv  = !out_vld_q || i_row_ready;
    rel      = out_vld_q && i_row_ready && out_last_q;
    dstate_d = dstate_q;
    rd_en    = 1'b0;
    rd_addr  = rd_cnt_q[AW-1:0];
    if (i_start) begin
      dstate_d = D_IDLE;
    end else begin
      case (dstate_q)
        D_IDLE: begin
          if (bank_full_q[drn_ptr_q]) begin
            rd_en    = 1'b1;
            rd_addr  = '0;
            dstate_d = D_RUN;
          end
        end
        D_RUN: begin
          if ((rd_cnt_q != (AW + 1)'(N)) && (!ram_vld_q || out_adv)) rd_en = 1'b1;
          if (rel) dstate_d = D_IDLE;
        end
        default: dstate_d = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate_q  <= D_IDLE;
      drn_ptr_q <= 1'b0;
      rd_cnt_q  <= '0;
      ram_vld_q <= 1'b0;
      ram_idx_q <= '0;
    end else if (i_start) begin
      dstate_q  <= D_IDLE;
      drn_ptr_q <= 1'b0;
      rd_cnt_q  <= '0;
      ram_vld_q <= 1'b0;
      ram_idx_q <= '0;
    end else begin
      dstate_q <= dstate_d;
      if (rel) drn_ptr_q <= ~drn_ptr_q;
      if (rd_en) begin
        rd_cnt_q  <= (dstate_q == D_IDLE) ? (AW + 1)'(1) : rd_cnt_q + 1'b1;
        ram_vld_q <= 1'b1;
        ram_idx_q <= rd_addr;
      end else if (out_adv) begin
        ram_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
    end else if (i_start) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
    end else if (out_adv) begin
      out_vld_q <= ram_vld_q;
      if (ram_vld_q) begin
        out_data_q <= rd_mux;
        out_idx_q  <= ram_idx_q;
        out_row_q  <= bank_row_q[drn_ptr_q];
        out_last_q <= (ram_idx_q == AW'(N - 1));
      end
    end
  end

  // ---------------------------------------------------------------- run control
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (rel && (out_row_q == k_q - 4'd1)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_start) begin
        k_q   <= i_k_param;
        ovf_q <= 1'b0;
      end else if (smp_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign o_row_valid = out_vld_q;
  assign o_row_data  = out_data_q;
  assign o_row_idx   = out_idx_q;
  assign o_row_i     = out_row_q;
  assign o_row_last  = out_last_q;
  assign o_busy      = (state_q == RUN);
  assign o_done      = (state_q == DONE);
  assign o_overflow  = ovf_q;

endmodule
